// File: rtl/lock_core_pkg.sv
// Shared types and default sizing for the locked-core arbiter.
package lock_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_BLOCK = 2'd2
  } lca_state_e;

  localparam int unsigned XW_DEF         = 13;
  localparam int unsigned YW_DEF         = 18;
  localparam int unsigned STEP_LIMIT_DEF = 255;

endpackage

// File: rtl/lock_rr_arb2.sv
// Two-way round-robin grant; the pointer favours requester 0 after reset or clear.
module lock_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [1:0] elig_i,
  output logic [1:0] gnt_o
);

  logic rr_q, rr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (elig_i == 2'b11) gnt_o = rr_q ? 2'b10 : 2'b01;
      else                 gnt_o = elig_i;
    end
    rr_d = rr_q;
    if (clr_i)         rr_d = 1'b0;
    else if (gnt_o[0]) rr_d = 1'b1;
    else if (gnt_o[1]) rr_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b0;
    else     rr_q <= rr_d;
  end

endmodule

// File: rtl/lock_core_arb.sv
// Shares one key-locked FSM core between two requesters, one core step per cycle.
// Optional step budget enabled by defining LCA_STEP_LIMIT_EN.
//
// state    | meaning (disposition of the previous cycle)
// ST_IDLE  | no grant, nothing pending
// ST_STEP  | a requester was granted a core step
// ST_BLOCK | a request was pending but no requester was eligible
module lock_core_arb
  import lock_core_pkg::*;
#(
  parameter int unsigned STEP_LIMIT = STEP_LIMIT_DEF,
  parameter int unsigned XW         = XW_DEF,
  parameter int unsigned YW         = YW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          soft_clr,
  input  logic          key_load,
  input  logic          key_in,
  input  logic          req0_valid,
  input  logic          req1_valid,
  input  logic [XW-1:0] req0_x,
  input  logic [XW-1:0] req1_x,
  output logic          req0_ready,
  output logic          req1_ready,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  output logic [YW-1:0] rsp0_y,
  output logic [YW-1:0] rsp1_y,
  input  logic          rsp0_ready,
  input  logic          rsp1_ready,
  output logic [XW-1:0] core_x,
  output logic          core_key,
  output logic          core_step,
  output logic          core_rst,
  input  logic [YW-1:0] core_y,
  output logic          limit_hit
);

  lca_state_e    state_q, state_d;
  logic          key_q, key_d, key_ok_q, key_ok_d;
  logic [1:0]    rsp_v_q, rsp_v_d;
  logic [YW-1:0] rsp0_y_q, rsp0_y_d, rsp1_y_q, rsp1_y_d;
  logic [1:0]    crst_q, crst_d;
  logic [1:0]    elig, gnt;
  logic          grant_en, pend;

  // core_rst covers the soft_clr cycle itself plus one trailing cycle
  assign core_rst   = soft_clr | crst_q[1];
  assign elig[0]    = req0_valid & (~rsp_v_q[0] | rsp0_ready);
  assign elig[1]    = req1_valid & (~rsp_v_q[1] | rsp1_ready);
  assign grant_en   = key_ok_q & ~core_rst & ~limit_hit;
  assign pend       = req0_valid | req1_valid;

  lock_rr_arb2 u_rr (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (soft_clr),
    .en_i   (grant_en),
    .elig_i (elig),
    .gnt_o  (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign core_step  = |gnt;
  assign core_x     = gnt[0] ? req0_x : (gnt[1] ? req1_x : '0);
  assign core_key   = key_q;
  assign rsp0_valid = rsp_v_q[0];
  assign rsp1_valid = rsp_v_q[1];
  assign rsp0_y     = rsp0_y_q;
  assign rsp1_y     = rsp1_y_q;

`ifdef LCA_STEP_LIMIT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (soft_clr)                        cnt_d = '0;
    else if (core_step && ~&cnt_q)       cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign limit_hit = (cnt_q == 16'(STEP_LIMIT));
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    key_d    = key_q;
    key_ok_d = key_ok_q;
    rsp_v_d  = rsp_v_q;
    rsp0_y_d = rsp0_y_q;
    rsp1_y_d = rsp1_y_q;
    crst_d   = {crst_q[0], 1'b0};
    if (soft_clr) begin
      key_ok_d = 1'b0;
      rsp_v_d  = 2'b00;
      crst_d   = 2'b10;
    end else begin
      if (key_load && !key_ok_q) begin
        key_d    = key_in;
        key_ok_d = 1'b1;
      end
      if (rsp_v_q[0] && rsp0_ready) rsp_v_d[0] = 1'b0;
      if (rsp_v_q[1] && rsp1_ready) rsp_v_d[1] = 1'b0;
      if (gnt[0]) begin
        rsp_v_d[0] = 1'b1;
        rsp0_y_d   = core_y;
      end
      if (gnt[1]) begin
        rsp_v_d[1] = 1'b1;
        rsp1_y_d   = core_y;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_STEP: state_d = core_step ? ST_STEP : (pend ? ST_BLOCK : ST_IDLE);
      ST_BLOCK: begin
        if (core_step) state_d = ST_STEP;
        else if (!pend) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      key_q    <= 1'b0;
      key_ok_q <= 1'b0;
      rsp_v_q  <= 2'b00;
      rsp0_y_q <= '0;
      rsp1_y_q <= '0;
      crst_q   <= 2'b11;
    end else begin
      state_q  <= state_d;
      key_q    <= key_d;
      key_ok_q <= key_ok_d;
      rsp_v_q  <= rsp_v_d;
      rsp0_y_q <= rsp0_y_d;
      rsp1_y_q <= rsp1_y_d;
      crst_q   <= crst_d;
    end
  end

endmodule
